btn_cond: RTL and testbench

Input-conditioning stage that sits directly upstream of the control FSM `conds`. It takes the raw run push-button and the 4-bit balance switch bank from board pins, and does three things: synchronises them to `clk`, debounces them, and presents clean signals to `conds`. Outputs are a single-cycle `run_pulse` per debounced press, and a stable `balance` value with an update strobe. It runs on the undivided board clock.

---
 rtl/btn_cond_pkg.sv | 17 +
 rtl/btn_cond_sync_2ff.sv | 25 ++
 rtl/btn_cond.sv | 134 +++++++++++++
 tb/tb_btn_cond.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/btn_cond_pkg.sv
// Shared types and defaults for the btn_cond input-conditioning stage.
// Holds the run-button FSM state encoding and the default debounce sizing.
package btn_cond_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } run_state_t;

  // 10 ms at 50 MHz; the counter must hold DB_CYCLES-1.
  localparam int DB_CYCLES_DEF = 500000;
  localparam int CNT_W_DEF     = 19;
  localparam int BAL_W         = 4;

endpackage

// File: rtl/btn_cond_sync_2ff.sv
// Parameterised-width two-flop synchroniser with asynchronous active-low
// reset; RST_VAL sets the level both stages load while in reset.
module sync_2ff #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/btn_cond.sv
// Synchronises and debounces the run push-button and balance switches,
// producing a one-cycle run_pulse per press and a strobed stable balance.
module btn_cond
  import btn_cond_pkg::*;
#(
  parameter int DB_CYCLES      = DB_CYCLES_DEF,
  parameter int CNT_W          = CNT_W_DEF,
  parameter bit RUN_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_btn,
  input  logic [BAL_W-1:0] balance_sw,
  output logic             run_pulse,
  output logic [BAL_W-1:0] balance,
  output logic             balance_upd,
  output run_state_t       run_state
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic             RUN_REL   = RUN_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic             RUN_PRESS = ~RUN_REL;

  logic             run_s2;
  logic [BAL_W-1:0] bal_s2;
  logic             pressed;

  sync_2ff #(.W(1), .RST_VAL(RUN_REL)) u_run_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (run_btn),
    .q     (run_s2)
  );

  sync_2ff #(.W(BAL_W), .RST_VAL('0)) u_bal_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (balance_sw),
    .q     (bal_s2)
  );

  assign pressed = (run_s2 == RUN_PRESS);

  // Run FSM: one counter shared by the press and release qualification windows.
  run_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      run_pulse <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      run_pulse <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!pressed) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to pressed returns to HELD without a second pulse.
        if (pressed) begin
          state_d = HELD;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign run_state = state_q;

  // Balance debouncer: any bit change restarts the window for the whole group.
  logic [BAL_W-1:0] cand_q;
  logic [CNT_W-1:0] bcnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand_q      <= '0;
      bcnt_q      <= '0;
      balance     <= '0;
      balance_upd <= 1'b0;
    end else begin
      balance_upd <= 1'b0;
      if (bal_s2 != cand_q) begin
        cand_q <= bal_s2;
        bcnt_q <= '0;
      end else if (bcnt_q == DB_LAST) begin
        if (cand_q != balance) begin
          balance     <= cand_q;
          balance_upd <= 1'b1;
        end
      end else begin
        bcnt_q <= bcnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_btn_cond.sv
// Directed bench for btn_cond (DB_CYCLES=4): expected strobe events are
// queued by the driver and matched by a monitor against cycle and value.
module tb_btn_cond;
  import btn_cond_pkg::*;

  localparam int W = 38;  // {cycle[31:0], run_pulse, balance_upd, balance[3:0]}

  logic             clk;
  logic             reset;
  logic             run_btn;
  logic [BAL_W-1:0] balance_sw;
  logic             run_pulse;
  logic [BAL_W-1:0] balance;
  logic             balance_upd;
  run_state_t       run_state;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;

  btn_cond #(.DB_CYCLES(4), .CNT_W(3), .RUN_ACTIVE_LOW(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .run_btn     (run_btn),
    .balance_sw  (balance_sw),
    .run_pulse   (run_pulse),
    .balance     (balance),
    .balance_upd (balance_upd),
    .run_state   (run_state)
  );

  // clock / cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_event(input int unsigned at, input logic rp,
                              input logic bu, input logic [3:0] bal);
    exp_q.push_back({at, rp, bu, bal});
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor / scoreboard: every strobe must match the head of the queue
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] exp;
    if (reset === 1'b1 && (run_pulse || balance_upd)) begin
      act = {cyc, run_pulse, balance_upd, balance};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe: got cyc=%0d run=%b upd=%b bal=%h, none expected",
                 cyc, run_pulse, balance_upd, balance);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          bad++;
          $display("FAIL strobe_event: got cyc=%0d run=%b upd=%b bal=%h expected cyc=%0d run=%b upd=%b bal=%h",
                   act[37:6], act[5], act[4], act[3:0], exp[37:6], exp[5], exp[4], exp[3:0]);
        end
      end
    end
  end

  initial begin
    int unsigned t;
    reset      = 1'b0;
    run_btn    = 1'b1;
    balance_sw = 4'h0;

    // 1: reset values, then 20 quiet cycles
    tick(3);
    check("rst_run_pulse", 32'(run_pulse), 32'd0);
    check("rst_balance", 32'(balance), 32'h0);
    check("rst_balance_upd", 32'(balance_upd), 32'd0);
    check("rst_state", 32'(run_state), 32'(IDLE));
    reset = 1'b1;
    tick(20);
    check("idle_balance", 32'(balance), 32'h0);

    // 2: held press -> one pulse 7 posedges after the drive point
    t = cyc;
    run_btn = 1'b0;
    expect_event(t + 7, 1'b1, 1'b0, 4'h0);
    tick(30);
    check("held_state", 32'(run_state), 32'(HELD));
    run_btn = 1'b1;
    tick(10);
    check("released_state", 32'(run_state), 32'(IDLE));

    // 3: short presses never qualify
    for (int i = 0; i < 5; i++) begin
      run_btn = 1'b0;
      tick(3);
      run_btn = 1'b1;
      tick(6);
    end
    check("glitch_state", 32'(run_state), 32'(IDLE));

    // 4: balance 0 -> 9, then a 2-cycle bit-0 glitch that returns
    t = cyc;
    balance_sw = 4'h9;
    expect_event(t + 7, 1'b0, 1'b1, 4'h9);
    tick(10);
    balance_sw = 4'h8;
    tick(2);
    balance_sw = 4'h9;
    tick(15);
    check("bal_after_glitch", 32'(balance), 32'h9);

    // 5: press and switch change on the same edge
    t = cyc;
    run_btn    = 1'b0;
    balance_sw = 4'h3;
    expect_event(t + 7, 1'b1, 1'b1, 4'h3);
    tick(10);

    // 6: reset pulse while held; re-qualification gives a fresh pulse and
    // the balance reloads from 0 to the still-set 3
    reset = 1'b0;
    #1;
    check("midrst_run_pulse", 32'(run_pulse), 32'd0);
    check("midrst_balance", 32'(balance), 32'h0);
    check("midrst_balance_upd", 32'(balance_upd), 32'd0);
    check("midrst_state", 32'(run_state), 32'(IDLE));
    tick(1);
    reset = 1'b1;
    t = cyc;
    expect_event(t + 7, 1'b1, 1'b1, 4'h3);
    tick(20);
    check("final_state", 32'(run_state), 32'(HELD));
    check("final_balance", 32'(balance), 32'h3);
    check("pending_events", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
